// File: rtl/f_fetch_unit_pkg.sv
// Shared definitions for the F-stage fetch unit.
//   f_state_e      : fetch FSM states (request, wait for data, hold for D)
//   F_RESET_PC     : PC after reset, first fetch address
//   F_EXC_VECTOR   : exception entry point, a typical flush target
//   F_IM_BASE/SIZE : default legal instruction window [base, base+size)
//   f_addr_illegal : combinational fetch-address legality test
package f_fetch_unit_pkg;

  typedef enum logic [1:0] {
    F_REQ  = 2'd0,
    F_WAIT = 2'd1,
    F_HOLD = 2'd2
  } f_state_e;

  localparam logic [31:0] F_RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] F_EXC_VECTOR = 32'h0000_4180;
  localparam logic [31:0] F_IM_BASE    = 32'h0000_3000;
  localparam logic [31:0] F_IM_SIZE    = 32'h0000_4000;

  // Misaligned or outside [base, base+size). The upper bound is formed in
  // 33 bits so a window that reaches the top of the address space does not wrap.
  function automatic logic f_addr_illegal(input logic [31:0] addr,
                                          input logic [31:0] base,
                                          input logic [31:0] size);
    logic [32:0] limit;
    limit = {1'b0, base} + {1'b0, size};
    return (addr[1:0] != 2'b00) || (addr < base) || ({1'b0, addr} >= limit);
  endfunction

endpackage

// File: rtl/f_fetch_unit_addr_check.sv
// Combinational fetch-address legality check, also usable by the D-stage
// jr target check.
//   addr    in  32  address to test
//   illegal out 1   misaligned or outside the instruction window
module f_fetch_unit_addr_check
  import f_fetch_unit_pkg::*;
#(
  parameter logic [31:0] IM_BASE = F_IM_BASE,
  parameter logic [31:0] IM_SIZE = F_IM_SIZE
) (
  input  logic [31:0] addr,
  output logic        illegal
);

  assign illegal = f_addr_illegal(addr, IM_BASE, IM_SIZE);

endmodule

// File: rtl/f_fetch_unit.sv
// F-stage fetch unit: owns the PC, reads the instruction memory for it,
// holds the fetched word for D and loads NPC once D accepts. A flush
// redirects to flush_pc from any state.
// Ports:
//   clk, reset                      clock; synchronous active-low reset
//   NPC, D_ready                    next PC from D and D-accept strobe
//   flush, flush_pc                 redirect request and target
//   imem_req/addr/gnt/rvalid/rdata  instruction-memory read port
//   F_PC, F_instr, F_valid, F_adel  fetch result presented to D
//   dbg_state, dbg_drop             FSM state and drop flag for observation
//
// Handshakes: imem_req is a request held high until the cycle imem_gnt is
// seen with it (a transfer happens when both are 1); each grant is answered
// by exactly one imem_rvalid pulse, in order. Toward D, F_valid offers the
// instruction and D_ready takes it; the pair is a transfer only when both
// are 1 in the same cycle, and F holds everything stable until then.
module f_fetch_unit
  import f_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = F_RESET_PC,
  parameter logic [31:0] IM_BASE  = F_IM_BASE,
  parameter logic [31:0] IM_SIZE  = F_IM_SIZE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] NPC,
  input  logic        D_ready,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] F_PC,
  output logic [31:0] F_instr,
  output logic        F_valid,
  output logic        F_adel,
  output f_state_e    dbg_state,
  output logic        dbg_drop
);

  localparam logic RESET_BAD = f_addr_illegal(RESET_PC, IM_BASE, IM_SIZE);

  f_state_e    state_q, state_n;
  logic [31:0] pc_q, pc_n;
  logic [31:0] instr_q, instr_n;
  logic        drop_q, drop_n;
  logic        adel_q, adel_n;
  logic        bad_q, bad_n;    // legality of pc_q, registered with it
  logic        req_q, req_n;

  f_fetch_unit_addr_check #(
    .IM_BASE (IM_BASE),
    .IM_SIZE (IM_SIZE)
  ) u_addr_check (
    .addr    (pc_n),
    .illegal (bad_n)
  );

  always_comb begin
    state_n = state_q;
    pc_n    = pc_q;
    instr_n = instr_q;
    drop_n  = drop_q;
    adel_n  = adel_q;

    // A response owed to an abandoned request is swallowed here.
    if (drop_q && imem_rvalid) drop_n = 1'b0;

    if (flush) begin
      state_n = F_REQ;
      pc_n    = flush_pc;
      adel_n  = 1'b0;
      // A request granted this cycle, or one already in flight whose data has
      // not arrived, will still produce a response that must be thrown away.
      if (state_q == F_REQ && req_q && imem_gnt) drop_n = 1'b1;
      if (state_q == F_WAIT && !imem_rvalid)     drop_n = 1'b1;
    end else begin
      case (state_q)
        F_REQ: begin
          if (req_q && imem_gnt) begin
            state_n = F_WAIT;
          end else if (!drop_q && bad_q) begin
            // Illegal PC: never touch memory, report it as an instruction.
            state_n = F_HOLD;
            adel_n  = 1'b1;
          end
        end
        F_WAIT: begin
          if (imem_rvalid) begin
            instr_n = imem_rdata;
            state_n = F_HOLD;
          end
        end
        F_HOLD: begin
          if (D_ready) begin
            pc_n    = NPC;
            adel_n  = 1'b0;
            state_n = F_REQ;
          end
        end
        default: state_n = F_REQ;
      endcase
    end

    // Registered request: asserted for the cycle after entering REQ with no
    // pending discard and a legal PC, dropped the cycle after the grant.
    req_n = (state_n == F_REQ) && !drop_n && !bad_n;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= F_REQ;
      pc_q    <= RESET_PC;
      instr_q <= 32'h0;
      drop_q  <= 1'b0;
      adel_q  <= 1'b0;
      bad_q   <= RESET_BAD;
      req_q   <= !RESET_BAD;
    end else begin
      state_q <= state_n;
      pc_q    <= pc_n;
      instr_q <= instr_n;
      drop_q  <= drop_n;
      adel_q  <= adel_n;
      bad_q   <= bad_n;
      req_q   <= req_n;
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = pc_q;
  assign F_PC      = pc_q;
  assign F_valid   = (state_q == F_HOLD);
  assign F_adel    = adel_q;
  assign F_instr   = (F_valid && !adel_q) ? instr_q : 32'h0;
  assign dbg_state = state_q;
  assign dbg_drop  = drop_q;

endmodule

// File: tb/tb_f_fetch_unit.sv
// Bench for f_fetch_unit: a latency-configurable memory responder, directed
// scenario tasks and a randomized instruction stream scored against a
// reference built from the fetch rules (address window, word contents).
module tb_f_fetch_unit;
  import f_fetch_unit_pkg::*;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] NPC = 32'h0;
  logic        D_ready = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] flush_pc = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] F_PC, F_instr;
  logic        F_valid, F_adel;
  f_state_e    dbg_state;
  logic        dbg_drop;

  always #5 clk = ~clk;

  f_fetch_unit dut (
    .clk(clk), .reset(reset), .NPC(NPC), .D_ready(D_ready),
    .flush(flush), .flush_pc(flush_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .F_PC(F_PC), .F_instr(F_instr), .F_valid(F_valid), .F_adel(F_adel),
    .dbg_state(dbg_state), .dbg_drop(dbg_drop)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_pc;          // PC the DUT should be fetching/holding
  logic [31:0] exp_q[$];        // expected instruction words, in fetch order

  // ---------------- reference rules ----------------
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h5A5A_0F0F;
  endfunction

  function automatic bit tb_illegal(input logic [31:0] a);
    return (a % 4 != 0) || (a < 32'h0000_3000) || (a >= 32'h0000_7000);
  endfunction

  function automatic logic [31:0] exp_word(input logic [31:0] a);
    return tb_illegal(a) ? 32'h0 : mem_word(a);
  endfunction

  // ---------------- memory responder ----------------
  bit          mem_on = 1'b0;
  int          gnt_lat = 0, rv_lat = 1;
  int          gnt_cnt = 0, rv_cnt = 0;
  bit          pend = 1'b0;
  logic [31:0] pend_addr = 32'h0;
  int          mem_gnts = 0, mem_rvs = 0;

  initial begin : mem_model
    forever begin
      @(negedge clk);
      imem_gnt = 1'b0;
      imem_rvalid = 1'b0;
      if (!mem_on) begin
        pend = 1'b0;
        gnt_cnt = 0;
      end else begin
        if (pend) begin
          rv_cnt--;
          if (rv_cnt <= 0) begin
            imem_rvalid = 1'b1;
            imem_rdata = mem_word(pend_addr);
            pend = 1'b0;
            mem_rvs++;
          end
        end
        if (imem_req === 1'b1) begin
          if (gnt_cnt >= gnt_lat) begin
            imem_gnt = 1'b1;
            pend = 1'b1;
            pend_addr = imem_addr;
            rv_cnt = rv_lat;
            gnt_cnt = 0;
            mem_gnts++;
          end else begin
            gnt_cnt++;
          end
        end else begin
          gnt_cnt = 0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic accept(input logic [31:0] npc);
    NPC = npc;
    D_ready = 1'b1;
    @(negedge clk);
    D_ready = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output bit ok, output int waited);
    ok = 1'b0;
    waited = budget;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (F_valid === 1'b1) begin
        ok = 1'b1;
        waited = i + 1;
        break;
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    bit ok; int w;
    reset = 1'b0; mem_on = 1'b0; gnt_lat = 0; rv_lat = 1;
    repeat (3) @(negedge clk);
    vectors++; if (F_PC !== F_RESET_PC) begin miscompares++; $display("FAIL reset_pc: got %h want %h", F_PC, F_RESET_PC); end
    vectors++; if (F_valid !== 1'b0 || F_instr !== 32'h0 || F_adel !== 1'b0) begin miscompares++; $display("FAIL reset_outputs: valid %b instr %h adel %b want 0 0 0", F_valid, F_instr, F_adel); end
    vectors++; if (dbg_drop !== 1'b0 || dbg_state !== F_REQ) begin miscompares++; $display("FAIL reset_state: drop %b state %0d want 0 %0d", dbg_drop, dbg_state, F_REQ); end
    reset = 1'b1;
    @(negedge clk);
    vectors++; if (imem_req !== 1'b1 || imem_addr !== F_RESET_PC) begin miscompares++; $display("FAIL first_req: req %b addr %h want 1 %h", imem_req, imem_addr, F_RESET_PC); end
    mem_on = 1'b1;
    exp_pc = F_RESET_PC;
    wait_valid(20, ok, w);
    vectors++; if (!ok || F_PC !== exp_pc || F_instr !== mem_word(exp_pc)) begin miscompares++; $display("FAIL first_fetch: ok %b pc %h instr %h want pc %h instr %h", ok, F_PC, F_instr, exp_pc, mem_word(exp_pc)); end
  endtask

  task automatic test_basic();
    bit ok; int w;
    gnt_lat = 0; rv_lat = 1;
    for (int i = 0; i < 3; i++) begin
      vectors++; if (F_valid !== 1'b1 || F_PC !== exp_pc || F_instr !== mem_word(exp_pc) || F_adel !== 1'b0) begin miscompares++; $display("FAIL basic_fetch%0d: valid %b pc %h instr %h want 1 %h %h", i, F_valid, F_PC, F_instr, exp_pc, mem_word(exp_pc)); end
      accept(exp_pc + 32'd4);
      exp_pc = exp_pc + 32'd4;
      wait_valid(10, ok, w);
      // 0-wait memory: one instruction per 3 cycles, accept cycle included
      vectors++; if (!ok || w + 1 != 3) begin miscompares++; $display("FAIL basic_spacing%0d: got %0d cycles want 3", i, w + 1); end
    end
  endtask

  task automatic test_stall();
    bit ok; int w;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors++; if (F_valid !== 1'b1 || F_PC !== exp_pc || F_instr !== mem_word(exp_pc) || imem_req !== 1'b0) begin miscompares++; $display("FAIL stall_hold%0d: valid %b pc %h instr %h req %b want 1 %h %h 0", i, F_valid, F_PC, F_instr, imem_req, exp_pc, mem_word(exp_pc)); end
    end
    accept(exp_pc + 32'd4);
    exp_pc = exp_pc + 32'd4;
    vectors++; if (F_valid !== 1'b0 || F_PC !== exp_pc || imem_req !== 1'b1) begin miscompares++; $display("FAIL stall_release: valid %b pc %h req %b want 0 %h 1", F_valid, F_PC, imem_req, exp_pc); end
    wait_valid(10, ok, w);
    vectors++; if (!ok || F_instr !== mem_word(exp_pc)) begin miscompares++; $display("FAIL stall_next: ok %b instr %h want %h", ok, F_instr, mem_word(exp_pc)); end
  endtask

  task automatic test_slow_mem();
    int req_cycles, g0, r0;
    bit got;
    gnt_lat = 4; rv_lat = 3;
    g0 = mem_gnts; r0 = mem_rvs;
    accept(exp_pc + 32'd4);
    exp_pc = exp_pc + 32'd4;
    req_cycles = 0; got = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (F_valid === 1'b1) begin got = 1'b1; break; end
      if (imem_req === 1'b1) begin
        req_cycles++;
        vectors++; if (imem_addr !== exp_pc) begin miscompares++; $display("FAIL slow_addr: got %h want %h", imem_addr, exp_pc); end
      end
      @(negedge clk);
    end
    vectors++; if (!got || req_cycles != gnt_lat + 1) begin miscompares++; $display("FAIL slow_req_hold: got %0d req cycles want %0d (valid seen %b)", req_cycles, gnt_lat + 1, got); end
    vectors++; if (mem_gnts - g0 != 1 || mem_rvs - r0 != 1) begin miscompares++; $display("FAIL slow_single: grants %0d responses %0d want 1 1", mem_gnts - g0, mem_rvs - r0); end
    vectors++; if (F_PC !== exp_pc || F_instr !== mem_word(exp_pc)) begin miscompares++; $display("FAIL slow_data: pc %h instr %h want %h %h", F_PC, F_instr, exp_pc, mem_word(exp_pc)); end
  endtask

  task automatic test_flush_wait();
    bit ok; int w, r0;
    gnt_lat = 0; rv_lat = 4;
    accept(exp_pc + 32'd4);
    @(negedge clk);
    vectors++; if (dbg_state !== F_WAIT) begin miscompares++; $display("FAIL flush_setup: state %0d want %0d", dbg_state, F_WAIT); end
    r0 = mem_rvs;
    flush = 1'b1; flush_pc = F_EXC_VECTOR;
    @(negedge clk);
    flush = 1'b0;
    exp_pc = F_EXC_VECTOR;
    vectors++; if (F_PC !== exp_pc || dbg_drop !== 1'b1 || imem_req !== 1'b0 || F_valid !== 1'b0) begin miscompares++; $display("FAIL flush_redirect: pc %h drop %b req %b valid %b want %h 1 0 0", F_PC, dbg_drop, imem_req, F_valid, exp_pc); end
    for (int i = 0; i < 20; i++) begin
      if (mem_rvs != r0) break;
      vectors++; if (imem_req !== 1'b0 || F_instr !== 32'h0) begin miscompares++; $display("FAIL flush_no_req: req %b instr %h want 0 0", imem_req, F_instr); end
      @(negedge clk);
    end
    wait_valid(20, ok, w);
    vectors++; if (!ok || F_PC !== exp_pc || F_instr !== mem_word(exp_pc) || F_adel !== 1'b0) begin miscompares++; $display("FAIL flush_first_word: ok %b pc %h instr %h want %h %h", ok, F_PC, F_instr, exp_pc, mem_word(exp_pc)); end
    vectors++; if (mem_rvs - r0 != 2) begin miscompares++; $display("FAIL flush_responses: got %0d want 2", mem_rvs - r0); end
  endtask

  task automatic test_adel();
    logic [31:0] pcs[5];
    bit ok; int w, g0;
    gnt_lat = 0; rv_lat = 1;
    pcs = '{32'h0000_3002, 32'h0000_2FFC, 32'h0000_6FFC, 32'h0000_7000, 32'h0000_3000};
    foreach (pcs[k]) begin
      g0 = mem_gnts;
      accept(pcs[k]);
      exp_pc = pcs[k];
      wait_valid(20, ok, w);
      vectors++; if (!ok || F_PC !== exp_pc) begin miscompares++; $display("FAIL adel_pc%0d: ok %b pc %h want %h", k, ok, F_PC, exp_pc); end
      vectors++; if (F_adel !== tb_illegal(exp_pc) || F_instr !== exp_word(exp_pc)) begin miscompares++; $display("FAIL adel_flag%0d: adel %b instr %h want %b %h", k, F_adel, F_instr, tb_illegal(exp_pc), exp_word(exp_pc)); end
      vectors++; if (mem_gnts - g0 != (tb_illegal(exp_pc) ? 0 : 1)) begin miscompares++; $display("FAIL adel_req%0d: grants %0d want %0d", k, mem_gnts - g0, tb_illegal(exp_pc) ? 0 : 1); end
    end
  endtask

  task automatic test_random();
    bit ok; int w, sel;
    logic [31:0] npc;
    logic [31:0] bad_pcs[5];
    logic [31:0] want;
    bad_pcs = '{32'h0000_2FFC, 32'h0000_7000, 32'h0000_3001, 32'hFFFF_FFFC, 32'h0000_0000};
    for (int it = 0; it < 40; it++) begin
      gnt_lat = $urandom_range(0, 3);
      rv_lat = $urandom_range(1, 3);
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        vectors++; if (F_valid !== 1'b1 || F_PC !== exp_pc) begin miscompares++; $display("FAIL rand_hold%0d: valid %b pc %h want 1 %h", it, F_valid, F_PC, exp_pc); end
      end
      sel = $urandom_range(0, 9);
      if (sel <= 5) npc = (exp_pc + 32'd4 >= 32'h0000_7000) ? 32'h0000_3000 : exp_pc + 32'd4;
      else if (sel <= 7) npc = 32'h0000_3000 + ($urandom_range(0, 32'hFFF) << 2);
      else if (sel == 8) npc = bad_pcs[$urandom_range(0, 4)];
      else npc = 32'h0000_3000 + ($urandom_range(0, 32'hFFF) << 2);
      if (sel == 9) begin
        // redirect while holding; a simultaneous D_ready must lose to it
        flush = 1'b1; flush_pc = npc;
        D_ready = 1'($urandom_range(0, 1));
        NPC = 32'h0000_3000;
        @(negedge clk);
        flush = 1'b0; D_ready = 1'b0;
      end else begin
        accept(npc);
      end
      exp_pc = npc;
      exp_q.push_back(exp_word(npc));
      wait_valid(40, ok, w);
      want = exp_q.pop_front();
      vectors++; if (!ok || F_PC !== exp_pc || F_instr !== want || F_adel !== tb_illegal(exp_pc)) begin miscompares++; $display("FAIL rand_fetch%0d: ok %b pc %h instr %h adel %b want %h %h %b", it, ok, F_PC, F_instr, F_adel, exp_pc, want, tb_illegal(exp_pc)); end
    end
  endtask

  task automatic test_reset_flush();
    bit ok; int w;
    gnt_lat = 0; rv_lat = 4;
    if (tb_illegal(exp_pc)) begin
      accept(32'h0000_3100);
      exp_pc = 32'h0000_3100;
      wait_valid(20, ok, w);
    end
    accept(exp_pc + 32'd4);
    @(negedge clk);
    vectors++; if (dbg_state !== F_WAIT) begin miscompares++; $display("FAIL rstflush_setup: state %0d want %0d", dbg_state, F_WAIT); end
    reset = 1'b0; flush = 1'b1; flush_pc = F_EXC_VECTOR; mem_on = 1'b0;
    @(negedge clk);
    vectors++; if (F_PC !== F_RESET_PC || F_valid !== 1'b0 || dbg_drop !== 1'b0 || dbg_state !== F_REQ) begin miscompares++; $display("FAIL rstflush_state: pc %h valid %b drop %b state %0d want %h 0 0 %0d", F_PC, F_valid, dbg_drop, dbg_state, F_RESET_PC, F_REQ); end
    reset = 1'b1; flush = 1'b0;
    @(negedge clk);
    mem_on = 1'b1;
    exp_pc = F_RESET_PC;
    wait_valid(20, ok, w);
    vectors++; if (!ok || F_PC !== exp_pc || F_instr !== mem_word(exp_pc)) begin miscompares++; $display("FAIL rstflush_refetch: ok %b pc %h instr %h want %h %h", ok, F_PC, F_instr, exp_pc, mem_word(exp_pc)); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    test_reset();
    test_basic();
    test_stall();
    test_slow_mem();
    test_flush_wait();
    test_adel();
    test_random();
    test_reset_flush();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
